// File: rtl/i2s_master_tx_pkg.sv
// Shared I2S framing constants and helpers for the bus-master transmitter.
// - Frame/channel widths and the bit index on which a new frame is loaded.
// - Layout of the 32-bit host word (left in the low half, right in the high half).
// - frame_order: reorders a host word into transmit order (left first, MSB first).
package i2s_master_tx_pkg;

    localparam int unsigned I2S_FRAME_BITS = 32;
    localparam int unsigned I2S_CH_BITS    = 16;
    localparam int unsigned LOAD_BIT       = 1;
    localparam int unsigned LEFT_LSB       = 0;
    localparam int unsigned RIGHT_LSB      = 16;

    typedef logic [I2S_FRAME_BITS-1:0] frame_t;

    typedef struct packed {
        logic [I2S_CH_BITS-1:0] right;
        logic [I2S_CH_BITS-1:0] left;
    } audio_word_t;

    function automatic frame_t frame_order(audio_word_t w);
        return {w.left, w.right};
    endfunction

endpackage

// File: rtl/i2s_master_tx_fifo.sv
// First-word-fall-through synchronous FIFO feeding the I2S transmitter.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset
//   srst   in   synchronous flush (pointers and count cleared every cycle while high)
//   din    in   write data
//   wr_en  in   write strobe; ignored while full
//   rd_en  in   pop strobe; ignored while empty
//   dout   out  head-of-queue word, valid whenever empty=0
//   full   out  registered, count == depth
//   empty  out  count == 0
module i2s_master_tx_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             srst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH     = 2 ** AW;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic [AW:0]      count_d;
    logic             full_q;
    logic             do_wr;
    logic             do_rd;

    assign do_wr = wr_en && !full_q;
    assign do_rd = rd_en && (count_q != '0);

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + 1'b1;
        end else if (!do_wr && do_rd) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_wr) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == DEPTH_CNT);
        end
    end

    // Storage has no reset so it can map onto block RAM; pointers define validity.
    always_ff @(posedge clk) begin
        if (do_wr && !srst) begin
            mem[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign full  = full_q;

endmodule

// File: rtl/i2s_master_tx.sv
// I2S bus-master transmitter: generates bit clock and word select from bus_clk and
// serializes stereo 16-bit samples drained from the host write stream.
// Ports:
//   bus_clk            in   single clock, rising edge
//   quiesce            in   asynchronous active-high reset
//   user_w_audio_wren  in   write strobe (only while full=0)
//   user_w_audio_full  out  FIFO full, registered
//   user_w_audio_data  in   [15:0] left, [31:16] right
//   user_w_audio_open  in   stream open; low holds the FIFO flushed
//   audio_bclk         out  bit clock, period 2*CLK_DIV bus_clk cycles
//   audio_lrclk        out  word select, 0 = left, 1 = right
//   audio_dac          out  serial data, MSB first, one bclk after lrclk edge
//   underrun           out  one-cycle pulse when a frame is due with the FIFO empty
//   underrun_cnt       out  saturating underrun count, cleared while closed
module i2s_master_tx
    import i2s_master_tx_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned FIFO_AW = 9
) (
    input  logic        bus_clk,
    input  logic        quiesce,
    input  logic        user_w_audio_wren,
    output logic        user_w_audio_full,
    input  logic [31:0] user_w_audio_data,
    input  logic        user_w_audio_open,
    output logic        audio_bclk,
    output logic        audio_lrclk,
    output logic        audio_dac,
    output logic        underrun,
    output logic [15:0] underrun_cnt
);

    localparam int unsigned DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(I2S_FRAME_BITS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] LOAD_CNT = BIT_W'(LOAD_BIT);

    logic [DIV_W-1:0] div_q, div_d;
    logic             bclk_q, bclk_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic             lrclk_q, lrclk_d;
    logic             dac_q, dac_d;
    frame_t           shreg_q, shreg_d;
    logic             underrun_q, underrun_d;
    logic [15:0]      underrun_cnt_q, underrun_cnt_d;

    logic             div_wrap;
    logic             fe;
    logic             load;
    logic [BIT_W-1:0] bit_cnt_inc;
    frame_t           load_word;

    logic [31:0]      fifo_dout;
    logic             fifo_empty;
    logic             fifo_full;

    i2s_master_tx_fifo #(
        .WIDTH (32),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk   (bus_clk),
        .rst   (quiesce),
        .srst  (!user_w_audio_open),
        .din   (user_w_audio_data),
        .wr_en (user_w_audio_wren),
        .rd_en (load && user_w_audio_open),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign div_wrap    = (div_q == DIV_LAST);
    // Falling bclk edge: the only point where bit counter, lrclk and dac move.
    assign fe          = div_wrap && bclk_q;
    assign bit_cnt_inc = bit_cnt_q + 1'b1;
    assign load        = fe && (bit_cnt_inc == LOAD_CNT);
    // Closed stream or empty FIFO sends a silent frame.
    assign load_word   = (user_w_audio_open && !fifo_empty) ?
                         frame_order(audio_word_t'(fifo_dout)) : '0;

    always_comb begin
        div_d     = div_wrap ? '0 : div_q + 1'b1;
        bclk_d    = div_wrap ? ~bclk_q : bclk_q;
        bit_cnt_d = bit_cnt_q;
        lrclk_d   = lrclk_q;
        dac_d     = dac_q;
        shreg_d   = shreg_q;
        if (fe) begin
            bit_cnt_d = bit_cnt_inc;
            lrclk_d   = bit_cnt_inc[BIT_W-1];
            // On a load the new word's MSB goes straight out and the rest is pre-shifted.
            if (load) begin
                {dac_d, shreg_d} = {load_word, 1'b0};
            end else begin
                {dac_d, shreg_d} = {shreg_q, 1'b0};
            end
        end
    end

    always_comb begin
        underrun_d     = load && user_w_audio_open && fifo_empty;
        underrun_cnt_d = underrun_cnt_q;
        if (!user_w_audio_open) begin
            underrun_cnt_d = '0;
        end else if (underrun_d && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) begin
            div_q          <= '0;
            bclk_q         <= 1'b0;
            bit_cnt_q      <= '0;
            lrclk_q        <= 1'b0;
            dac_q          <= 1'b0;
            shreg_q        <= '0;
            underrun_q     <= 1'b0;
            underrun_cnt_q <= '0;
        end else begin
            div_q          <= div_d;
            bclk_q         <= bclk_d;
            bit_cnt_q      <= bit_cnt_d;
            lrclk_q        <= lrclk_d;
            dac_q          <= dac_d;
            shreg_q        <= shreg_d;
            underrun_q     <= underrun_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign audio_bclk        = bclk_q;
    assign audio_lrclk       = lrclk_q;
    assign audio_dac         = dac_q;
    assign underrun          = underrun_q;
    assign underrun_cnt      = underrun_cnt_q;
    assign user_w_audio_full = fifo_full;

endmodule

// File: tb/tb_i2s_master_tx.sv
// Directed bench for i2s_master_tx (CLK_DIV=4, 8-word FIFO).
// Timeline reference: cyc counts bus_clk rising edges since quiesce release.
// bclk rises at cyc 4,12,20..; falling edge k lands on cyc 8k; frame loads at cyc 8+256m.
module tb_i2s_master_tx;

    logic        bus_clk = 1'b0;
    logic        quiesce = 1'b1;
    logic        wren = 1'b0;
    logic [31:0] data = '0;
    logic        open = 1'b0;
    logic        full;
    logic        audio_bclk;
    logic        audio_lrclk;
    logic        audio_dac;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    logic [31:0] words [9];

    i2s_master_tx #(
        .CLK_DIV (4),
        .FIFO_AW (3)
    ) dut (
        .bus_clk           (bus_clk),
        .quiesce           (quiesce),
        .user_w_audio_wren (wren),
        .user_w_audio_full (full),
        .user_w_audio_data (data),
        .user_w_audio_open (open),
        .audio_bclk        (audio_bclk),
        .audio_lrclk       (audio_lrclk),
        .audio_dac         (audio_dac),
        .underrun          (underrun),
        .underrun_cnt      (underrun_cnt)
    );

    always #5 bus_clk = ~bus_clk;

    always @(posedge bus_clk or posedge quiesce) begin
        if (quiesce) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    // Returns on the falling bus_clk edge after rising edge n.
    task automatic wait_until(input int n);
        while (cyc < n) @(negedge bus_clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge bus_clk);
        n_checks++;
        if ({audio_bclk, audio_lrclk, audio_dac, full, underrun} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {audio_bclk, audio_lrclk, audio_dac, full, underrun});
        end
        n_checks++;
        if (underrun_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_cnt: got %h want 0000", underrun_cnt);
        end
        quiesce = 1'b0;
    endtask

    task automatic test_clocks();
        int  pts [9];
        logic eb, el;
        pts = '{3, 4, 7, 8, 12, 127, 128, 255, 256};
        for (int i = 0; i < 9; i++) begin
            wait_until(pts[i]);
            eb = ((pts[i] / 4) % 2) == 1;
            el = ((pts[i] / 8) % 32) >= 16;
            n_checks++;
            if (audio_bclk !== eb) begin
                n_fail++;
                $display("FAIL bclk@%0d: got %b want %b", pts[i], audio_bclk, eb);
            end
            n_checks++;
            if (audio_lrclk !== el) begin
                n_fail++;
                $display("FAIL lrclk@%0d: got %b want %b", pts[i], audio_lrclk, el);
            end
            n_checks++;
            if ({audio_dac, full} !== 2'b00) begin
                n_fail++;
                $display("FAIL idle_dac_full@%0d: got %b want 00", pts[i], {audio_dac, full});
            end
        end
        wait_until(264);
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL closed_no_underrun: got %b want 0", underrun);
        end
    endtask

    task automatic test_serial();
        logic [31:0] s;
        logic        el;
        wait_until(299);
        open = 1'b1;
        wait_until(300);
        wren = 1'b1;
        data = 32'h8001_A5C3;
        wait_until(301);
        wren = 1'b0;
        wait_until(520);
        n_checks++;
        if ({underrun, full} !== 2'b00) begin
            n_fail++;
            $display("FAIL serial_load: underrun,full got %b want 00", {underrun, full});
        end
        s = 32'hA5C3_8001;
        for (int j = 0; j < 32; j++) begin
            wait_until(524 + 8 * j);
            el = ((j + 1) % 32) >= 16;
            n_checks++;
            if (audio_dac !== s[31-j]) begin
                n_fail++;
                $display("FAIL serial_bit%0d: got %b want %b", j, audio_dac, s[31-j]);
            end
            n_checks++;
            if (audio_lrclk !== el) begin
                n_fail++;
                $display("FAIL serial_lrclk%0d: got %b want %b", j, audio_lrclk, el);
            end
        end
    endtask

    task automatic test_underrun();
        int l;
        for (int m = 0; m < 3; m++) begin
            l = 776 + 256 * m;
            wait_until(l);
            n_checks++;
            if (underrun !== 1'b1 || underrun_cnt !== 16'(m + 1)) begin
                n_fail++;
                $display("FAIL underrun_%0d: got pulse=%b cnt=%0d want pulse=1 cnt=%0d",
                         m, underrun, underrun_cnt, m + 1);
            end
            wait_until(l + 1);
            n_checks++;
            if (underrun !== 1'b0) begin
                n_fail++;
                $display("FAIL underrun_width_%0d: got %b want 0", m, underrun);
            end
            wait_until(l + 4);
            n_checks++;
            if (audio_dac !== 1'b0) begin
                n_fail++;
                $display("FAIL underrun_dac_%0d: got %b want 0", m, audio_dac);
            end
        end
        wait_until(1300);
        open = 1'b0;
        wait_until(1301);
        n_checks++;
        if (underrun_cnt !== 16'h0) begin
            n_fail++;
            $display("FAIL close_clears_cnt: got %h want 0000", underrun_cnt);
        end
    endtask

    task automatic test_fill_drain();
        logic [31:0] s;
        int l;
        wait_until(1550);
        open = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_until(1550 + i);
            if (i == 7) begin
                n_checks++;
                if (full !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_at_7: got %b want 0", full);
                end
            end
            wren = 1'b1;
            data = words[i];
        end
        wait_until(1558);
        n_checks++;
        if (full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_at_8: got %b want 1", full);
        end
        data = words[8];
        wait_until(1559);
        wren = 1'b0;
        n_checks++;
        if (full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_hold: got %b want 1", full);
        end
        wait_until(1800);
        n_checks++;
        if ({full, underrun} !== 2'b00) begin
            n_fail++;
            $display("FAIL full_after_pop: full,underrun got %b want 00", {full, underrun});
        end
        for (int f = 0; f < 8; f++) begin
            l = 1800 + 256 * f;
            s = {words[f][15:0], words[f][31:16]};
            for (int j = 0; j < 32; j++) begin
                wait_until(l + 4 + 8 * j);
                n_checks++;
                if (audio_dac !== s[31-j]) begin
                    n_fail++;
                    $display("FAIL drain_w%0d_bit%0d: got %b want %b",
                             f, j, audio_dac, s[31-j]);
                end
            end
        end
        // Write lands on the same edge as an empty-FIFO frame load: no bypass.
        wait_until(3847);
        wren = 1'b1;
        data = 32'h2468_ACE1;
        wait_until(3848);
        wren = 1'b0;
        n_checks++;
        if (underrun !== 1'b1 || underrun_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL load_write: got pulse=%b cnt=%0d want pulse=1 cnt=1",
                     underrun, underrun_cnt);
        end
        wait_until(3852);
        n_checks++;
        if (audio_dac !== 1'b0) begin
            n_fail++;
            $display("FAIL load_write_dac: got %b want 0", audio_dac);
        end
        wait_until(4104);
        n_checks++;
        if (underrun !== 1'b0) begin
            n_fail++;
            $display("FAIL late_word_underrun: got %b want 0", underrun);
        end
        s = 32'hACE1_2468;
        for (int j = 0; j < 32; j++) begin
            wait_until(4108 + 8 * j);
            n_checks++;
            if (audio_dac !== s[31-j]) begin
                n_fail++;
                $display("FAIL late_word_bit%0d: got %b want %b", j, audio_dac, s[31-j]);
            end
        end
    endtask

    task automatic test_saturation();
        wait_until(4400);
        force dut.underrun_cnt_q = 16'hFFFE;
        wait_until(4401);
        release dut.underrun_cnt_q;
        wait_until(4402);
        n_checks++;
        if (underrun_cnt !== 16'hFFFE) begin
            n_fail++;
            $display("FAIL sat_preload: got %h want fffe", underrun_cnt);
        end
        wait_until(4616);
        n_checks++;
        if (underrun !== 1'b1 || underrun_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_reach: got pulse=%b cnt=%h want pulse=1 cnt=ffff",
                     underrun, underrun_cnt);
        end
        wait_until(4872);
        n_checks++;
        if (underrun !== 1'b1 || underrun_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL sat_hold: got pulse=%b cnt=%h want pulse=1 cnt=ffff",
                     underrun, underrun_cnt);
        end
    endtask

    task automatic test_quiesce();
        for (int i = 0; i < 3; i++) begin
            wait_until(4900 + i);
            wren = 1'b1;
            data = words[i];
        end
        wait_until(4903);
        wren = 1'b0;
        wait_until(4996);
        n_checks++;
        if ({audio_bclk, audio_lrclk} !== 2'b11) begin
            n_fail++;
            $display("FAIL pre_quiesce: bclk,lrclk got %b want 11", {audio_bclk, audio_lrclk});
        end
        quiesce = 1'b1;
        #1;
        n_checks++;
        if ({audio_bclk, audio_lrclk, audio_dac, full, underrun, underrun_cnt} !== 21'b0) begin
            n_fail++;
            $display("FAIL quiesce_async: got %b want all zero",
                     {audio_bclk, audio_lrclk, audio_dac, full, underrun, underrun_cnt});
        end
        @(negedge bus_clk);
        quiesce = 1'b0;
        wait_until(7);
        n_checks++;
        if ({audio_bclk, underrun} !== 2'b10) begin
            n_fail++;
            $display("FAIL post_quiesce_7: bclk,underrun got %b want 10", {audio_bclk, underrun});
        end
        wait_until(8);
        n_checks++;
        if ({audio_bclk, audio_lrclk, underrun} !== 3'b001 || underrun_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL post_quiesce_fe: bclk,lrclk,underrun got %b cnt=%0d want 001 cnt=1",
                     {audio_bclk, audio_lrclk, underrun}, underrun_cnt);
        end
    endtask

    initial begin
        words = '{32'h0001_8000, 32'hFFFF_0000, 32'h1234_5678, 32'hDEAD_BEEF,
                  32'h5555_AAAA, 32'h0F0F_F0F0, 32'h7FFF_8001, 32'hC3A5_3C5A,
                  32'h9999_6666};
        test_reset();
        test_clocks();
        test_serial();
        test_underrun();
        test_fill_drain();
        test_saturation();
        test_quiesce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
